// File: rtl/seconds_display.sv
// Sequential double-dabble converter feeding a multiplexed 4-digit seven-segment display.
// Conversion takes 10 cycles; one strobe arriving mid-conversion is held pending.
module seconds_display #(
  parameter int REFRESH_COUNT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] seconds_in,
  input  logic       seconds_valid,
  output logic       busy,
  output logic [3:0] an,
  output logic [6:0] seg
);

  typedef enum logic {IDLE, CONVERT} state_t;

  localparam int CW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_COUNT - 1);

  state_t      state, state_nxt;
  logic [25:0] shift, shift_nxt, step;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic        pend, pend_nxt;
  logic [9:0]  pend_val, pend_val_nxt;
  logic [15:0] digits, digits_nxt;

  logic [CW-1:0] refresh;
  logic [1:0]    idx, idx_nxt;
  logic          wrap, blank;
  logic [3:0]    cur;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    seg_pat = 7'b1000000;
      4'd1:    seg_pat = 7'b1111001;
      4'd2:    seg_pat = 7'b0100100;
      4'd3:    seg_pat = 7'b0110000;
      4'd4:    seg_pat = 7'b0011001;
      4'd5:    seg_pat = 7'b0010010;
      4'd6:    seg_pat = 7'b0000010;
      4'd7:    seg_pat = 7'b1111000;
      4'd8:    seg_pat = 7'b0000000;
      4'd9:    seg_pat = 7'b0010000;
      default: seg_pat = 7'b1111111;
    endcase
  endfunction

  // One double-dabble iteration: correct BCD nibbles >= 5, then shift left.
  always_comb begin
    logic [25:0] adj;
    adj = shift;
    for (int i = 0; i < 4; i++) begin
      if (adj[10+4*i +: 4] >= 4'd5)
        adj[10+4*i +: 4] = adj[10+4*i +: 4] + 4'd3;
    end
    step = {adj[24:0], 1'b0};
  end

  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    bit_cnt_nxt  = bit_cnt;
    pend_nxt     = pend;
    pend_val_nxt = pend_val;
    digits_nxt   = digits;
    case (state)
      IDLE: begin
        if (seconds_valid) begin
          shift_nxt   = {16'd0, seconds_in};
          bit_cnt_nxt = 4'd0;
          pend_nxt    = 1'b0;
          state_nxt   = CONVERT;
        end else if (pend) begin
          shift_nxt   = {16'd0, pend_val};
          bit_cnt_nxt = 4'd0;
          pend_nxt    = 1'b0;
          state_nxt   = CONVERT;
        end
      end
      CONVERT: begin
        shift_nxt   = step;
        bit_cnt_nxt = bit_cnt + 4'd1;
        if (seconds_valid) begin
          pend_nxt     = 1'b1;
          pend_val_nxt = seconds_in;
        end
        if (bit_cnt == 4'd9) begin
          digits_nxt = step[25:10];
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      pend     <= 1'b0;
      pend_val <= '0;
      digits   <= '0;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      bit_cnt  <= bit_cnt_nxt;
      pend     <= pend_nxt;
      pend_val <= pend_val_nxt;
      digits   <= digits_nxt;
    end
  end

  assign busy = (state == CONVERT);

  // Outputs are computed from the post-wrap index so an/seg move on the wrap edge itself.
  assign wrap    = (refresh == LAST);
  assign idx_nxt = wrap ? idx + 2'd1 : idx;
  assign cur     = digits[{idx_nxt, 2'b00} +: 4];

  always_comb begin
    case (idx_nxt)
      2'd1:    blank = (digits[15:4] == 12'd0);
      2'd2:    blank = (digits[15:8] == 8'd0);
      2'd3:    blank = (digits[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh <= '0;
      idx     <= 2'd0;
      an      <= 4'b1110;
      seg     <= 7'b1000000;
    end else begin
      refresh <= wrap ? '0 : refresh + CW'(1);
      idx     <= idx_nxt;
      an      <= ~(4'b0001 << idx_nxt);
      seg     <= blank ? 7'b1111111 : seg_pat(cur);
    end
  end

endmodule

// File: tb/tb_seconds_display.sv
// Scoreboard bench: expected conversions queued by stimulus, display checked every cycle.
module tb_seconds_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] seconds_in;
  logic       seconds_valid;
  logic       busy;
  logic [3:0] an;
  logic [6:0] seg;

  seconds_display #(.REFRESH_COUNT(4)) dut (
    .clk(clk), .rst(rst), .seconds_in(seconds_in), .seconds_valid(seconds_valid),
    .busy(busy), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int sb[$];
  int disp = 0;
  int run = 0;
  int edges = 0;

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int pow10 [4] = '{1, 10, 100, 1000};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_seg(input int v, input int k);
    if (k > 0 && v < pow10[k]) return 7'h7F;
    return int'(pat[(v / pow10[k]) % 10]);
  endfunction

  // Edges since reset release: the digit index is (edges / 4) mod 4.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  always @(negedge clk) begin
    int k;
    if (rst) begin
      sb.delete();
      run  = 0;
      disp = 0;
      check("rst_an", int'(an), 4'b1110);
      check("rst_seg", int'(seg), 7'b1000000);
      check("rst_busy", int'(busy), 0);
    end else begin
      k = (edges / 4) % 4;
      check("scan_an", int'(an), int'(~(4'b0001 << k) & 4'hF));
      check("scan_seg", int'(seg), exp_seg(disp, k));
      if (busy) run++;
      else if (run > 0) begin
        check("busy_len", run, 10);
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL sb_pop: conversion finished with no expected value queued");
        end else begin
          disp = sb.pop_front();
        end
        run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int v);
    seconds_in    = 10'(v);
    seconds_valid = 1'b1;
    tick();
    seconds_valid = 1'b0;
  endtask

  initial begin
    int v0, last, w;
    bit has;
    rst = 1'b1;
    seconds_in = '0;
    seconds_valid = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(40);

    sb.push_back(59);
    send(59);
    idle(30);

    // Pending overwritten: 600 at convert cycle 3, 7 on the final cycle.
    sb.push_back(1023);
    send(1023);
    idle(2);
    send(600);
    idle(6);
    sb.push_back(7);
    send(7);
    idle(40);

    sb.push_back(1000);
    send(1000);
    idle(30);

    sb.push_back(345);
    send(345);
    idle(4);
    rst = 1'b1;
    #1;
    check("abort_an", int'(an), 4'b1110);
    check("abort_seg", int'(seg), 7'b1000000);
    check("abort_busy", int'(busy), 0);
    tick();
    tick();
    rst = 1'b0;
    idle(20);
    sb.push_back(8);
    send(8);
    idle(30);

    for (int ep = 0; ep < 30; ep++) begin
      v0 = $urandom_range(0, 1023);
      sb.push_back(v0);
      send(v0);
      has = 1'b0;
      last = 0;
      for (int i = 1; i <= 10; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          last = $urandom_range(0, 1023);
          has = 1'b1;
          send(last);
        end else begin
          idle(1);
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        w = $urandom_range(0, 1023);
        sb.push_back(w);
        send(w);
      end else if (has) begin
        sb.push_back(last);
      end
      idle(25);
    end

    idle(20);
    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seconds_display.md
SECONDS_DISPLAY -- requirements
Module: seconds_display

Interface
REQ-001 The module SHALL have parameter REFRESH_COUNT, default 100000, giving the clock cycles each digit is displayed (legal range >= 1).
REQ-002 The module SHALL have input clk, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The module SHALL have input rst, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have input seconds_in, 10 bits: unsigned binary seconds count, 0..1023.
REQ-005 The module SHALL have input seconds_valid, 1 bit: strobe marking that seconds_in holds a new value to show.
REQ-006 The module SHALL have output busy, 1 bit: high while a binary-to-BCD conversion runs.
REQ-007 The module SHALL have output an, 4 bits: active-low one-hot digit enable; bit 0 drives the least significant digit.
REQ-008 The module SHALL have output seg, 7 bits: active-low segments in {g,f,e,d,c,b,a} order, bit 6 = g.

Function
REQ-009 The converter SHALL be a two-state machine, IDLE and CONVERT, running sequential shift-and-add-3 (double dabble) on 10 bits.
REQ-010 In IDLE, seconds_valid=1 SHALL capture seconds_in into the shift register at that edge and move to CONVERT.
REQ-011 CONVERT SHALL last exactly 10 cycles, one bit per cycle: add 3 to every BCD nibble >= 5, then shift left by one.
REQ-012 On the 10th CONVERT edge, the four BCD digits SHALL be written into the display-digit registers together and the state SHALL return to IDLE.
REQ-013 busy SHALL be high in exactly the 10 cycles spent in CONVERT; the display digits for a value accepted at edge N SHALL update at edge N+10.
REQ-014 seconds_valid=1 in CONVERT, including the final cycle, SHALL store seconds_in in a one-deep pending register and set a pending flag; a later strobe SHALL overwrite the stored value.
REQ-015 In IDLE with pending set, the pending value SHALL be captured as in REQ-010 and the flag cleared; if seconds_valid is also high that cycle, the live seconds_in SHALL win and pending SHALL be discarded.
REQ-016 Until a conversion completes, the display digits SHALL NOT change; a partial conversion SHALL never be displayed.
REQ-017 A refresh counter SHALL count 0..REFRESH_COUNT-1 and wrap; at wrap the digit index SHALL advance 0->1->2->3->0.
REQ-018 an SHALL be registered and SHALL drive low only the bit equal to the digit index.
REQ-019 seg SHALL be registered and SHALL hold the active-low pattern for the indexed digit. Patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 Leading-zero blanking: every digit above the most significant nonzero digit SHALL show seg=1111111; digit 0 SHALL always be shown.
REQ-021 Inputs 1000..1023 SHALL display all four digits, for example 1023 -> "1023".
REQ-022 an and seg SHALL change only on a refresh wrap or on the cycle after the display digits update.

Reset
REQ-023 Asserting rst SHALL immediately force: state IDLE, busy=0, pending flag cleared, shift register 0, display digits 0, refresh counter 0, digit index 0, an=1110, seg=1000000.
REQ-024 Reset asserted during CONVERT SHALL abort the conversion; the aborted value SHALL NOT reach the display.
REQ-025 After rst deasserts, scanning SHALL resume from digit 0 on the next edge; no seconds_valid SHALL be needed to display "0".

Verification (REFRESH_COUNT=4)
REQ-026 Reset release, no strobe -> an cycles 1110,1101,1011,0111 every 4 clocks; seg=1000000 on digit 0, 1111111 on digits 1-3.
REQ-027 seconds_in=59 strobed at edge N -> busy high for 10 cycles; digits update at N+10; digit 0 seg=0010000, digit 1 seg=0010010, digits 2-3 blank.
REQ-028 seconds_in=1023, then a strobe with 600 on cycle 3 of CONVERT, then 7 on cycle 10 -> 1023 displayed, then 7 converted immediately (busy low 1 cycle), 600 never shown.
REQ-029 seconds_in=1000 -> digits 1,0,0,0, all shown; interior zeros not blanked.
REQ-030 rst pulsed on cycle 5 of converting 345 -> outputs match REQ-023 at once; "345" never appears; a new strobe of 8 afterward displays "8".
